fetch_unit: RTL

- Instruction fetch stage plus IF/ID register, directly upstream of the control unit.
- Drives the instruction-memory address from the PC and assembles one- and two-word instructions.
- Presents a 9-bit opcode, the full instruction word and an immediate word to the decode stage.
- Handles stalls and branch redirects coming from later stages.

---
 rtl/fetch_unit_if.sv | 61 ++++++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory bus, the hazard/redirect controls and the
// IF/ID register outputs of the fetch stage.
//
// Signals:
//   imem_addr    fetch -> imem   instruction-memory address (current PC)
//   imem_rdata   imem  -> fetch  16-bit word at imem_addr, same-cycle read
//   stall        later -> fetch  hold request from the hazard unit
//   redirect     later -> fetch  branch taken / flush request
//   redirect_pc  later -> fetch  new PC when redirect=1
//   if_id_valid  fetch -> decode IF/ID holds a real instruction
//   if_id_instr  fetch -> decode first instruction word
//   if_id_opcode fetch -> decode if_id_instr[15:7]
//   if_id_imm    fetch -> decode second word of a two-word instruction, else 0
//   if_id_pc     fetch -> decode address of the first word
//
// Modports:
//   master  the fetch unit
//   slave   the environment (memory, hazard unit, decode)
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_id_valid;
    logic [15:0]       if_id_instr;
    logic [8:0]        if_id_opcode;
    logic [15:0]       if_id_imm;
    logic [ADDR_W-1:0] if_id_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output if_id_valid,
        output if_id_instr,
        output if_id_opcode,
        output if_id_imm,
        output if_id_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output redirect,
        output redirect_pc,
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_opcode,
        input  if_id_imm,
        input  if_id_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage plus IF/ID register. Drives the instruction-memory
// address from the PC, assembles one- and two-word instructions and presents
// them to decode. LDM/LDD/STD carry a second (immediate) word; every other
// opcode is one word.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     fetch_unit_if.master (imem bus, stall/redirect, IF/ID outputs)
//   fetch_count, bubble_count  (only with FETCH_PERF_CNT_EN) 32-bit counters
//
// Parameters:
//   ADDR_W        PC / instruction-memory address width
//   RESET_VECTOR  PC value loaded on reset
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, fetch_count counts edges that load a valid instruction into
//   IF/ID and bubble_count counts bubbles caused by redirect or IMM entry.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  bubble_count
`endif
);

    typedef enum logic {
        FIRST = 1'b0,
        IMM   = 1'b1
    } state_e;

    localparam logic [8:0] OP_LDM = 9'b0_0110_0010;
    localparam logic [8:0] OP_LDD = 9'b0_0110_0011;
    localparam logic [8:0] OP_STD = 9'b0_0110_0100;

    function automatic logic is_two_word(input logic [8:0] op);
        return (op == OP_LDM) || (op == OP_LDD) || (op == OP_STD);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       hold_q, hold_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic              valid_q, valid_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       imm_q, imm_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              fetch_evt;
    logic              bubble_evt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        hold_pc_d  = hold_pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        imm_d      = imm_q;
        if_pc_d    = if_pc_q;
        fetch_evt  = 1'b0;
        bubble_evt = 1'b0;

        if (bus.redirect) begin
            // Flush: any half-assembled two-word instruction is dropped.
            pc_d       = bus.redirect_pc;
            state_d    = FIRST;
            valid_d    = 1'b0;
            bubble_evt = 1'b1;
        end else if (!bus.stall) begin
            pc_d = pc_q + ADDR_W'(1);
            case (state_q)
                FIRST: begin
                    if (is_two_word(bus.imem_rdata[15:7])) begin
                        hold_d     = bus.imem_rdata;
                        hold_pc_d  = pc_q;
                        state_d    = IMM;
                        valid_d    = 1'b0;
                        bubble_evt = 1'b1;
                    end else begin
                        instr_d   = bus.imem_rdata;
                        imm_d     = 16'h0000;
                        if_pc_d   = pc_q;
                        valid_d   = 1'b1;
                        fetch_evt = 1'b1;
                    end
                end
                IMM: begin
                    // The word on the bus now is data, never an opcode.
                    instr_d   = hold_q;
                    imm_d     = bus.imem_rdata;
                    if_pc_d   = hold_pc_q;
                    valid_d   = 1'b1;
                    state_d   = FIRST;
                    fetch_evt = 1'b1;
                end
                default: state_d = FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FIRST;
            pc_q      <= RESET_VECTOR;
            hold_q    <= '0;
            hold_pc_q <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            imm_q     <= '0;
            if_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_q    <= hold_d;
            hold_pc_q <= hold_pc_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            if_pc_q   <= if_pc_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.if_id_instr  = instr_q;
    assign bus.if_id_opcode = instr_q[15:7];
    assign bus.if_id_imm    = imm_q;
    assign bus.if_id_pc     = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, fetch_evt};
        bubble_cnt_d = bubble_cnt_q + {31'd0, bubble_evt};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    // Event strobes only feed the optional counters.
    logic unused_evt;
    assign unused_evt = fetch_evt ^ bubble_evt;
`endif

endmodule
